// File: rtl/snake_body_ctrl_if.sv
// snake_body_ctrl_if
// Groups the game-control inputs, the renderer query port and the status
// outputs of snake_body_ctrl into one bundle.
//   slave  : the controller (drives the o* signals)
//   master : the game logic / renderer / testbench (drives the i* signals)
// Signals:
//   iTick, iDir[1:0], iGrow, iRestart         : step request and restart
//   iQuery_Valid, iQuery_X[6:0], iQuery_Y[5:0] : renderer cell query
//   oHit, oHit_Valid                           : query answer, one cycle later
//   oHead_X, oHead_Y, oLength                  : snake status
//   oBusy, oDead, oStep_Done                   : engine status
//   oState[2:0]                                : FSM state, for debug/checkers
interface snake_body_ctrl_if;
  logic       iTick;
  logic [1:0] iDir;
  logic       iGrow;
  logic       iRestart;
  logic       iQuery_Valid;
  logic [6:0] iQuery_X;
  logic [5:0] iQuery_Y;
  logic       oHit;
  logic       oHit_Valid;
  logic [6:0] oHead_X;
  logic [5:0] oHead_Y;
  logic [6:0] oLength;
  logic       oBusy;
  logic       oDead;
  logic       oStep_Done;
  logic [2:0] oState;

  modport slave (
    input  iTick, iDir, iGrow, iRestart, iQuery_Valid, iQuery_X, iQuery_Y,
    output oHit, oHit_Valid, oHead_X, oHead_Y, oLength, oBusy, oDead,
           oStep_Done, oState
  );

  modport master (
    output iTick, iDir, iGrow, iRestart, iQuery_Valid, iQuery_X, iQuery_Y,
    input  oHit, oHit_Valid, oHead_X, oHead_Y, oLength, oBusy, oDead,
           oStep_Done, oState
  );
endinterface

// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl
// Owns the snake body as a circular {y,x} FIFO plus a GRID_W x GRID_H
// occupancy bitmap, advances the snake one cell per game tick, detects wall
// and self collisions and answers per-cell occupancy queries for the renderer.
// Ports:
//   iCLK   : clock
//   iRST_N : asynchronous active-low reset
//   bus    : snake_body_ctrl_if.slave (control, query port, status)
//
// Handshake: there is no backpressure anywhere. iTick is a one-cycle strobe
// accepted only in IDLE while alive (otherwise dropped); iQuery_Valid is
// answered unconditionally one cycle later on oHit/oHit_Valid. The bitmap
// has one port and the renderer owns it whenever iQuery_Valid=1, so every
// step state simply holds while a query is present.
module snake_body_ctrl #(
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 48,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 4,
  parameter int INIT_X   = 32,
  parameter int INIT_Y   = 24
) (
  input logic              iCLK,
  input logic              iRST_N,
  snake_body_ctrl_if.slave bus
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int PW    = $clog2(MAX_LEN);
  localparam int CW    = $clog2(CELLS + INIT_LEN + 1);

  localparam logic [1:0] DIR_UP    = 2'b11;
  localparam logic [1:0] DIR_DOWN  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b01;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_CALC, ST_LOOK, ST_CLEAR_TAIL, ST_SET_HEAD
  } state_t;

  function automatic logic [11:0] cell_addr(input logic [6:0] x, input logic [5:0] y);
    return 12'(y) * 12'(GRID_W) + 12'(x);
  endfunction

  logic          bitmap_q [CELLS];
  logic [12:0]   fifo_q   [MAX_LEN];

  state_t        state_q;
  logic [CW-1:0] init_cnt_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [1:0]    heading_q;
  logic          grow_q;
  logic [6:0]    next_x_q, head_x_q, length_q;
  logic [5:0]    next_y_q, head_y_q;
  logic          dead_q, step_done_q, hit_q, hit_valid_q;

  // Combinational helpers
  logic          stall, q_in_range, rd_bit, wall_hit;
  logic [11:0]   q_addr, next_addr, tail_addr, rd_addr;
  logic [12:0]   tail_entry;
  logic [1:0]    dir_eff;
  logic [6:0]    nx_d;
  logic [5:0]    ny_d;
  logic [CW-1:0] seg_idx;
  logic [6:0]    seg_x;

  // Memory write port
  logic          bm_we, bm_wdata, fifo_we;
  logic [11:0]   bm_addr;
  logic [PW-1:0] fifo_waddr;
  logic [12:0]   fifo_wdata;

  assign stall      = bus.iQuery_Valid;
  assign q_in_range = (bus.iQuery_X < 7'(GRID_W)) && (bus.iQuery_Y < 6'(GRID_H));
  assign q_addr     = cell_addr(bus.iQuery_X, bus.iQuery_Y);
  assign next_addr  = cell_addr(next_x_q, next_y_q);
  assign tail_entry = fifo_q[rd_ptr_q];
  assign tail_addr  = cell_addr(tail_entry[6:0], tail_entry[12:7]);
  // Single read port: the query owns it when present, else the step engine.
  assign rd_addr    = stall ? q_addr : next_addr;
  assign rd_bit     = bitmap_q[rd_addr];
  assign seg_idx    = init_cnt_q - CW'(CELLS);
  assign seg_x      = 7'(INIT_X - INIT_LEN + 1) + 7'(seg_idx);

  // Direction resolution and wall check for CALC.
  always_comb begin
    dir_eff  = (bus.iDir == ~heading_q) ? heading_q : bus.iDir;
    nx_d     = head_x_q;
    ny_d     = head_y_q;
    wall_hit = 1'b0;
    case (dir_eff)
      DIR_UP: begin
        wall_hit = (head_y_q == 6'd0);
        ny_d     = head_y_q - 6'd1;
      end
      DIR_DOWN: begin
        wall_hit = (head_y_q == 6'(GRID_H - 1));
        ny_d     = head_y_q + 6'd1;
      end
      DIR_LEFT: begin
        wall_hit = (head_x_q == 7'd0);
        nx_d     = head_x_q - 7'd1;
      end
      default: begin
        wall_hit = (head_x_q == 7'(GRID_W - 1));
        nx_d     = head_x_q + 7'd1;
      end
    endcase
  end

  // Memory write decode: INIT clears every cell then lays down the initial
  // body tail first; the step engine writes only when no query is present.
  always_comb begin
    bm_we      = 1'b0;
    bm_addr    = tail_addr;
    bm_wdata   = 1'b0;
    fifo_we    = 1'b0;
    fifo_waddr = wr_ptr_q;
    fifo_wdata = {next_y_q, next_x_q};
    case (state_q)
      ST_INIT: begin
        bm_we = 1'b1;
        if (init_cnt_q < CW'(CELLS)) begin
          bm_addr = 12'(init_cnt_q);
        end else begin
          bm_addr    = cell_addr(seg_x, 6'(INIT_Y));
          bm_wdata   = 1'b1;
          fifo_we    = 1'b1;
          fifo_waddr = PW'(seg_idx);
          fifo_wdata = {6'(INIT_Y), seg_x};
        end
      end
      ST_CLEAR_TAIL: bm_we = !stall && !grow_q;
      ST_SET_HEAD: begin
        bm_we    = !stall;
        bm_addr  = next_addr;
        bm_wdata = 1'b1;
        fifo_we  = !stall;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (bm_we)   bitmap_q[bm_addr]  <= bm_wdata;
    if (fifo_we) fifo_q[fifo_waddr] <= fifo_wdata;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      heading_q   <= DIR_RIGHT;
      grow_q      <= 1'b0;
      next_x_q    <= 7'(INIT_X);
      next_y_q    <= 6'(INIT_Y);
      head_x_q    <= 7'(INIT_X);
      head_y_q    <= 6'(INIT_Y);
      length_q    <= '0;
      dead_q      <= 1'b0;
      step_done_q <= 1'b0;
      hit_q       <= 1'b0;
      hit_valid_q <= 1'b0;
    end else begin
      hit_valid_q <= bus.iQuery_Valid;
      hit_q       <= bus.iQuery_Valid && (state_q != ST_INIT) && q_in_range && rd_bit;
      step_done_q <= 1'b0;
      if (bus.iRestart) begin
        state_q    <= ST_INIT;
        init_cnt_q <= '0;
        dead_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_INIT: begin
            init_cnt_q <= init_cnt_q + 1'b1;
            if (init_cnt_q == CW'(CELLS + INIT_LEN - 1)) begin
              state_q   <= ST_IDLE;
              rd_ptr_q  <= '0;
              wr_ptr_q  <= PW'(INIT_LEN);
              heading_q <= DIR_RIGHT;
              length_q  <= 7'(INIT_LEN);
              head_x_q  <= 7'(INIT_X);
              head_y_q  <= 6'(INIT_Y);
            end
          end
          ST_IDLE: if (bus.iTick && !dead_q) state_q <= ST_CALC;
          ST_CALC: if (!stall) begin
            heading_q <= dir_eff;
            grow_q    <= bus.iGrow && (length_q < 7'(MAX_LEN));
            if (wall_hit) begin
              dead_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              next_x_q <= nx_d;
              next_y_q <= ny_d;
              state_q  <= ST_LOOK;
            end
          end
          ST_LOOK: if (!stall) begin
            // Entering the tail cell is legal when the tail leaves this step.
            if (rd_bit && !(!grow_q && (next_addr == tail_addr))) begin
              dead_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_CLEAR_TAIL;
            end
          end
          ST_CLEAR_TAIL: if (!stall) begin
            if (!grow_q) rd_ptr_q <= rd_ptr_q + 1'b1;
            state_q <= ST_SET_HEAD;
          end
          ST_SET_HEAD: if (!stall) begin
            wr_ptr_q    <= wr_ptr_q + 1'b1;
            head_x_q    <= next_x_q;
            head_y_q    <= next_y_q;
            length_q    <= length_q + 7'(grow_q);
            step_done_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
          default: state_q <= ST_INIT;
        endcase
      end
    end
  end

  assign bus.oHit       = hit_q;
  assign bus.oHit_Valid = hit_valid_q;
  assign bus.oHead_X    = head_x_q;
  assign bus.oHead_Y    = head_y_q;
  assign bus.oLength    = length_q;
  assign bus.oBusy      = (state_q != ST_IDLE);
  assign bus.oDead      = dead_q;
  assign bus.oStep_Done = step_done_q;
  assign bus.oState     = state_q;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// tb_snake_body_ctrl
// Directed bench for snake_body_ctrl. A reference model of the snake (body
// as a queue of cells, plain coordinate arithmetic) runs beside the DUT and
// a compare process checks every output each cycle; the main sequence pins
// the model with hand-computed literal expectations.
module tb_snake_body_ctrl;
  localparam int GW       = 64;
  localparam int GH       = 48;
  localparam int INIT_CYC = GW * GH + 4;

  logic clk;
  logic rst_n;
  bit   cmp_en;
  int   n_checks;
  int   n_fail;

  snake_body_ctrl_if bus();

  snake_body_ctrl #(
    .GRID_W(64), .GRID_H(48), .MAX_LEN(64), .INIT_LEN(4), .INIT_X(32), .INIT_Y(24)
  ) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int body[$];
  int m_init_left, m_k, m_hx, m_hy, m_len, m_heading, m_nx, m_ny;
  bit m_active, m_dead, m_done, m_hit, m_hv, m_grow;

  function automatic bit occ(input int x, input int y);
    foreach (body[i]) if (body[i] == y * GW + x) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int d, qx, qy;
    if (!rst_n) begin
      body.delete();
      m_init_left = INIT_CYC;
      m_active = 0; m_k = 0;
      m_hx = 32; m_hy = 24; m_len = 0; m_heading = 1;
      m_dead = 0; m_done = 0; m_hit = 0; m_hv = 0; m_grow = 0;
    end else begin
      qx = int'(bus.iQuery_X);
      qy = int'(bus.iQuery_Y);
      m_hv  = bus.iQuery_Valid;
      m_hit = bus.iQuery_Valid && (m_init_left == 0) && qx < GW && qy < GH && occ(qx, qy);
      m_done = 0;
      if (bus.iRestart) begin
        m_dead = 0; m_init_left = INIT_CYC; m_active = 0; body.delete();
      end else if (m_init_left > 0) begin
        m_init_left--;
        if (m_init_left == 0) begin
          body.delete();
          for (int i = 0; i < 4; i++) body.push_back(24 * GW + 29 + i);
          m_hx = 32; m_hy = 24; m_len = 4; m_heading = 1;
        end
      end else if (!m_active) begin
        if (bus.iTick && !m_dead) begin
          m_active = 1; m_k = 0;
        end
      end else if (!bus.iQuery_Valid) begin
        m_k++;
        case (m_k)
          1: begin
            d = int'(bus.iDir);
            if (d != 3 - m_heading) m_heading = d;
            m_grow = bus.iGrow && (m_len < 64);
            m_nx = m_hx; m_ny = m_hy;
            case (m_heading)
              3: m_ny = m_hy - 1;
              0: m_ny = m_hy + 1;
              2: m_nx = m_hx - 1;
              default: m_nx = m_hx + 1;
            endcase
            if (m_nx < 0 || m_nx >= GW || m_ny < 0 || m_ny >= GH) begin
              m_dead = 1; m_active = 0;
            end
          end
          2: if (occ(m_nx, m_ny) && !(!m_grow && body[0] == m_ny * GW + m_nx)) begin
            m_dead = 1; m_active = 0;
          end
          3: if (!m_grow) void'(body.pop_front());
          default: begin
            body.push_back(m_ny * GW + m_nx);
            m_hx = m_nx; m_hy = m_ny;
            m_len = m_len + int'(m_grow);
            m_done = 1; m_active = 0;
          end
        endcase
      end
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (rst_n && cmp_en) begin
      chk("cyc_hit_valid", bus.oHit_Valid, m_hv);
      if (m_hv) chk("cyc_hit", bus.oHit, m_hit);
      chk("cyc_head_x", bus.oHead_X, m_hx);
      chk("cyc_head_y", bus.oHead_Y, m_hy);
      chk("cyc_length", bus.oLength, m_len);
      chk("cyc_busy", bus.oBusy, int'(m_init_left > 0 || m_active));
      chk("cyc_dead", bus.oDead, m_dead);
      chk("cyc_step_done", bus.oStep_Done, m_done);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic query(input int x, input int y, input int exp, input string nm);
    @(negedge clk);
    bus.iQuery_Valid = 1'b1; bus.iQuery_X = 7'(x); bus.iQuery_Y = 6'(y);
    @(posedge clk); #1;
    chk(nm, bus.oHit, exp);
    @(negedge clk);
    bus.iQuery_Valid = 1'b0;
  endtask

  // lat = edges after the tick edge until oStep_Done; 0 if the engine went
  // idle without a step; -1 if the budget ran out.
  task automatic step(input logic [1:0] d, input logic g, output int lat);
    @(negedge clk);
    bus.iTick = 1'b1; bus.iDir = d; bus.iGrow = g;
    @(negedge clk);
    bus.iTick = 1'b0;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (bus.oStep_Done) begin lat = i; break; end
      if (!bus.oBusy) begin lat = 0; break; end
    end
  endtask

  task automatic wait_init(input string nm);
    for (int i = 1; i <= INIT_CYC; i++) begin
      @(posedge clk); #1;
      if (i == INIT_CYC - 1) chk({nm, "_busy_last"}, bus.oBusy, 1);
    end
    chk({nm, "_idle"}, bus.oBusy, 0);
    chk({nm, "_len"}, bus.oLength, 4);
    chk({nm, "_hx"}, bus.oHead_X, 32);
    chk({nm, "_hy"}, bus.oHead_Y, 24);
    chk({nm, "_dead"}, bus.oDead, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, bad_hit, done_seen;
    n_checks = 0; n_fail = 0; cmp_en = 0;
    bus.iTick = 0; bus.iDir = 2'b01; bus.iGrow = 0; bus.iRestart = 0;
    bus.iQuery_Valid = 0; bus.iQuery_X = '0; bus.iQuery_Y = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_hit", bus.oHit, 0);
    chk("rst_hit_valid", bus.oHit_Valid, 0);
    chk("rst_dead", bus.oDead, 0);
    chk("rst_step_done", bus.oStep_Done, 0);
    chk("rst_length", bus.oLength, 0);
    chk("rst_hx", bus.oHead_X, 32);
    chk("rst_hy", bus.oHead_Y, 24);
    chk("rst_busy", bus.oBusy, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; cmp_en = 1;

    // Abort init part-way with reset; init must start over.
    repeat (100) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1 chk("midinit_rst_busy", bus.oBusy, 1);
    @(negedge clk); rst_n = 1'b1;

    // Queries during init are answered with oHit=0.
    bus.iQuery_Valid = 1'b1; bus.iQuery_X = 7'd32; bus.iQuery_Y = 6'd24;
    wait_init("init");
    @(negedge clk); bus.iQuery_Valid = 1'b0;

    query(29, 24, 1, "init_q29"); query(30, 24, 1, "init_q30");
    query(31, 24, 1, "init_q31"); query(32, 24, 1, "init_q32");
    query(28, 24, 0, "init_q28");

    // Straight step right.
    step(2'b01, 1'b0, lat);
    chk("straight_lat", lat, 4);
    chk("straight_hx", bus.oHead_X, 33);
    chk("straight_hy", bus.oHead_Y, 24);
    query(29, 24, 0, "straight_q29"); query(33, 24, 1, "straight_q33");

    // Reversal is ignored, then grow.
    step(2'b10, 1'b0, lat);
    chk("reverse_lat", lat, 4);
    chk("reverse_hx", bus.oHead_X, 34);
    step(2'b01, 1'b1, lat);
    chk("grow_len", bus.oLength, 5);
    chk("grow_hx", bus.oHead_X, 35);
    query(31, 24, 1, "grow_tail_kept");

    // Query arbitration: hold the port for 100 cycles after the tick.
    @(negedge clk); bus.iTick = 1'b1; bus.iDir = 2'b01; bus.iGrow = 1'b0;
    @(negedge clk); bus.iTick = 1'b0;
    bus.iQuery_Valid = 1'b1; bus.iQuery_X = 7'd31; bus.iQuery_Y = 6'd24;
    bad_hit = 0; done_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!bus.oHit || !bus.oHit_Valid) bad_hit++;
      if (bus.oStep_Done) done_seen++;
    end
    chk("arb_hold_hits", bad_hit, 0);
    chk("arb_no_done", done_seen, 0);
    chk("arb_head_held", bus.oHead_X, 35);
    @(negedge clk); bus.iQuery_Valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (bus.oStep_Done) begin lat = i; break; end
    end
    chk("arb_lat_after_drop", lat, 4);
    chk("arb_hx", bus.oHead_X, 36);
    query(31, 24, 0, "arb_tail_cleared");

    // Self collision with length 5.
    step(2'b11, 1'b0, lat); chk("self_up_hy", bus.oHead_Y, 23);
    step(2'b10, 1'b0, lat); chk("self_left_hx", bus.oHead_X, 35);
    step(2'b00, 1'b0, lat);
    chk("self_lat", lat, 0);
    chk("self_dead", bus.oDead, 1);
    chk("self_hx", bus.oHead_X, 35);
    chk("self_hy", bus.oHead_Y, 23);
    chk("self_len", bus.oLength, 5);
    step(2'b01, 1'b0, lat);
    chk("dead_tick_ignored", lat, 0);
    chk("dead_head_same", bus.oHead_X, 35);

    // Restart.
    @(negedge clk); bus.iRestart = 1'b1;
    @(negedge clk); bus.iRestart = 1'b0;
    chk("restart_dead", bus.oDead, 0);
    chk("restart_busy", bus.oBusy, 1);
    repeat (INIT_CYC - 1) @(posedge clk);
    @(posedge clk); #1;
    chk("restart_idle", bus.oBusy, 0);
    chk("restart_len", bus.oLength, 4);

    // Tail chase in a 2x2 loop with length 4.
    step(2'b11, 1'b0, lat);
    step(2'b10, 1'b0, lat);
    step(2'b00, 1'b0, lat);
    chk("chase1_lat", lat, 4);
    chk("chase1_dead", bus.oDead, 0);
    step(2'b01, 1'b0, lat);
    chk("chase2_lat", lat, 4);
    chk("chase_len", bus.oLength, 4);
    chk("chase_hx", bus.oHead_X, 32);
    chk("chase_hy", bus.oHead_Y, 24);
    query(31, 24, 1, "chase_q31"); query(30, 24, 0, "chase_q30");

    // Wall: climb to row 0, then one more step up.
    bad_hit = 0;
    for (int i = 0; i < 24; i++) begin
      step(2'b11, 1'b0, lat);
      if (lat != 4) bad_hit++;
    end
    chk("climb_steps", bad_hit, 0);
    chk("climb_hy", bus.oHead_Y, 0);
    step(2'b11, 1'b0, lat);
    chk("wall_lat", lat, 0);
    chk("wall_dead", bus.oDead, 1);
    chk("wall_hy", bus.oHead_Y, 0);
    chk("wall_hx", bus.oHead_X, 32);
    step(2'b10, 1'b0, lat);
    chk("wall_tick_ignored", lat, 0);
    @(negedge clk); bus.iRestart = 1'b1;
    @(negedge clk); bus.iRestart = 1'b0;
    chk("wall_restart_dead", bus.oDead, 0);
    repeat (INIT_CYC - 1) @(posedge clk);
    @(posedge clk); #1;
    chk("wall_restart_idle", bus.oBusy, 0);
    chk("wall_restart_hy", bus.oHead_Y, 24);

    repeat (3) @(negedge clk);
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
